// File: rtl/memory_request_arbiter.sv
// memory_request_arbiter
//
// Purpose:
//   Shares one line-oriented memory controller between an instruction-fetch
//   port (read only) and a data port (read or write). A request is granted in
//   IDLE, its direction/address/write line are latched, and the transaction
//   runs through BUSY -> RELEASE -> ACK before the next one can start. Read
//   beats from the controller are collected into a two-beat line buffer that
//   both ports observe. Write beats are served to the controller from the
//   latched write line.
//
// Configuration macro:
//   ARB_FIXED_PRIORITY_EN  defined   : data port always wins a tie and there
//                                      is no last-grant register.
//                          undefined : round-robin between the two ports,
//                                      instruction port wins the first tie.
//
// Ports:
//   i_mem_clk, i_mem_rst     clock, asynchronous active-high reset
//   i_ic_req/i_ic_addr       instruction-port read request and line address
//   o_ic_ack/o_ic_rdata      instruction-port completion pulse and line
//   i_dc_req/i_dc_we         data-port request and write enable
//   i_dc_addr/i_dc_wdata     data-port line address and write line
//   o_dc_ack/o_dc_rdata      data-port completion pulse and line
//   o_mem_en/o_mem_we        transaction request and direction to controller
//   o_mem_addr               transaction line address
//   o_mem_rcv                one-cycle "completion received" pulse
//   i_mem_done               controller completion indication
//   i_rd_valid/i_rd_index    read beat strobe and beat index
//   i_rd_data                read beat data
//   i_wr_index/o_wr_data     write beat select and selected write beat

module memory_request_arbiter #(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned DATA_W = 64
) (
  input  logic                i_mem_clk,
  input  logic                i_mem_rst,

  input  logic                i_ic_req,
  input  logic [ADDR_W-1:0]   i_ic_addr,
  output logic                o_ic_ack,
  output logic [2*DATA_W-1:0] o_ic_rdata,

  input  logic                i_dc_req,
  input  logic                i_dc_we,
  input  logic [ADDR_W-1:0]   i_dc_addr,
  input  logic [2*DATA_W-1:0] i_dc_wdata,
  output logic                o_dc_ack,
  output logic [2*DATA_W-1:0] o_dc_rdata,

  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_rcv,
  input  logic                i_mem_done,

  input  logic                i_rd_valid,
  input  logic                i_rd_index,
  input  logic [DATA_W-1:0]   i_rd_data,

  input  logic                i_wr_index,
  output logic [DATA_W-1:0]   o_wr_data
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusy    = 2'd1,
    StRelease = 2'd2,
    StAck     = 2'd3
  } state_e;

  state_e                state_q;

  // Latched transaction attributes.
  logic                  grant_dc_q;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [2*DATA_W-1:0]   wdata_q;

  // Registered handshake outputs.
  logic                  mem_en_q;
  logic                  mem_rcv_q;
  logic                  ic_ack_q;
  logic                  dc_ack_q;

  // Two-beat read line buffer; beats may land in either order.
  logic [DATA_W-1:0]     beat0_q;
  logic [DATA_W-1:0]     beat1_q;

  // Arbitration decision for the current IDLE cycle.
  logic                  grant_dc;

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    grant_dc = i_dc_req;
  end
`else
  // Set when the data port held the most recent grant.
  logic                  last_dc_q;

  // A lone request wins outright; on a tie the port not granted last wins.
  always_comb begin
    grant_dc = i_dc_req & (~i_ic_req | ~last_dc_q);
  end
`endif

  always_ff @(posedge i_mem_clk or posedge i_mem_rst) begin
    if (i_mem_rst) begin
      state_q    <= StIdle;
      grant_dc_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_rcv_q  <= 1'b0;
      ic_ack_q   <= 1'b0;
      dc_ack_q   <= 1'b0;
      beat0_q    <= '0;
      beat1_q    <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      last_dc_q  <= 1'b1;
`endif
    end else begin
      // Read beats are captured regardless of state.
      if (i_rd_valid) begin
        if (i_rd_index) begin
          beat1_q <= i_rd_data;
        end else begin
          beat0_q <= i_rd_data;
        end
      end

      unique case (state_q)
        StIdle: begin
          mem_rcv_q <= 1'b0;
          ic_ack_q  <= 1'b0;
          dc_ack_q  <= 1'b0;
          if (i_ic_req || i_dc_req) begin
            grant_dc_q <= grant_dc;
            we_q       <= grant_dc & i_dc_we;
            addr_q     <= grant_dc ? i_dc_addr : i_ic_addr;
            wdata_q    <= grant_dc ? i_dc_wdata : '0;
            mem_en_q   <= 1'b1;
`ifndef ARB_FIXED_PRIORITY_EN
            last_dc_q  <= grant_dc;
`endif
            state_q    <= StBusy;
          end
        end

        StBusy: begin
          if (i_mem_done) begin
            mem_en_q  <= 1'b0;
            mem_rcv_q <= 1'b1;
            state_q   <= StRelease;
          end
        end

        StRelease: begin
          mem_rcv_q <= 1'b0;
          ic_ack_q  <= ~grant_dc_q;
          dc_ack_q  <= grant_dc_q;
          state_q   <= StAck;
        end

        StAck: begin
          ic_ack_q <= 1'b0;
          dc_ack_q <= 1'b0;
          state_q  <= StIdle;
        end

        default: begin
          mem_en_q  <= 1'b0;
          mem_rcv_q <= 1'b0;
          ic_ack_q  <= 1'b0;
          dc_ack_q  <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign o_mem_en   = mem_en_q;
  assign o_mem_we   = we_q;
  assign o_mem_addr = addr_q;
  assign o_mem_rcv  = mem_rcv_q;
  assign o_ic_ack   = ic_ack_q;
  assign o_dc_ack   = dc_ack_q;

  // Both ports see the same buffer; contents only matter while acked.
  assign o_ic_rdata = {beat1_q, beat0_q};
  assign o_dc_rdata = {beat1_q, beat0_q};

  assign o_wr_data  = i_wr_index ? wdata_q[2*DATA_W-1:DATA_W] : wdata_q[DATA_W-1:0];

endmodule
